// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered execute-stage ALU with handshake and iterative mul/div (optional, macro ALU_SEQ_MULDIV_EN)
module alu_seq #(
    parameter int XLEN = 64,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            flush_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [3:0]      op_in,
    input  logic            sub_sra_in,
    input  logic [1:0]      src1_in,
    input  logic [1:0]      src2_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    input  logic [XLEN-1:0] imm_value_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] result_out,
    output logic            non_zero_out,
    output logic            busy_out
);

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_HOLD} state_t;
`else
    typedef enum logic {S_IDLE, S_HOLD} state_t;
`endif

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              non_zero_q, non_zero_d;
    logic [XLEN-1:0]   op_a, op_b, alu_res;
    logic [SHW-1:0]    shamt;
    logic signed [XLEN-1:0] sra_res;

`ifdef ALU_SEQ_MULDIV_EN
    // prod_q holds {hi, lo}: multiplier/product for MUL, {remainder, quotient} for DIV
    logic [2*XLEN-1:0] prod_q, prod_d, step_prod, mul_prod;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [1:0]        opsel_q, opsel_d;
    logic              sign1_q, sign1_d, sign2_q, sign2_d;
    logic              s1_signed, s2_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_abs, b_abs, mul_res, div_q, div_r, iter_res;
    logic [XLEN:0]     mul_sum, div_trial;
`endif

    // operand source selection; encoding 3 is illegal and propagates X
    always_comb begin
        case (src1_in)
            2'd0:    op_a = rs1_value_in;
            2'd1:    op_a = pc_in;
            2'd2:    op_a = '0;
            default: op_a = 'x;
        endcase
        case (src2_in)
            2'd0:    op_b = rs2_value_in;
            2'd1:    op_b = imm_value_in;
            2'd2:    op_b = XLEN'(4);
            default: op_b = 'x;
        endcase
    end

    // single-cycle integer ops 0-7
    always_comb begin
        shamt   = op_b[SHW-1:0];
        sra_res = $signed(op_a) >>> shamt;
        case (op_in[2:0])
            3'd0:    alu_res = sub_sra_in ? op_a - op_b : op_a + op_b;
            3'd1:    alu_res = op_a ^ op_b;
            3'd2:    alu_res = op_a | op_b;
            3'd3:    alu_res = op_a & op_b;
            3'd4:    alu_res = op_a << shamt;
            3'd5:    alu_res = sub_sra_in ? XLEN'(sra_res) : op_a >> shamt;
            3'd6:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            default: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // operand sign stripping, one shift-add / restoring-divide step, and final sign fix-up
    always_comb begin
        s1_signed = (op_in == 4'd9) || (op_in == 4'd10) || (op_in == 4'd12) || (op_in == 4'd14);
        s2_signed = (op_in == 4'd9) || (op_in == 4'd12) || (op_in == 4'd14);
        a_neg     = s1_signed && op_a[XLEN-1];
        b_neg     = s2_signed && op_b[XLEN-1];
        a_abs     = a_neg ? -op_a : op_a;
        b_abs     = b_neg ? -op_b : op_b;
        div_zero  = (op_b == '0);
        div_ovf   = s2_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        div_trial = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]} - {1'b0, opb_q};
        if (state_q == S_MUL)
            step_prod = {mul_sum, prod_q[XLEN-1:1]};
        else if (!div_trial[XLEN])
            step_prod = {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        else
            step_prod = {prod_q[2*XLEN-2:0], 1'b0};
        mul_prod = (sign1_q ^ sign2_q) ? -step_prod : step_prod;
        mul_res  = (opsel_q == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
        div_q    = (sign1_q ^ sign2_q) ? -step_prod[XLEN-1:0] : step_prod[XLEN-1:0];
        div_r    = sign1_q ? -step_prod[2*XLEN-1:XLEN] : step_prod[2*XLEN-1:XLEN];
        iter_res = (state_q == S_MUL) ? mul_res : (opsel_q[1] ? div_r : div_q);
    end
`endif

    // next-state, result register and iteration control
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifdef ALU_SEQ_MULDIV_EN
        prod_d  = prod_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        opsel_d = opsel_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
`endif
        if (flush_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (state_q == S_IDLE || ready_in) begin
                        if (!valid_in) begin
                            state_d = S_IDLE;
                        end else if (!op_in[3]) begin
                            result_d = alu_res;
                            state_d  = S_HOLD;
                        end else begin
`ifdef ALU_SEQ_MULDIV_EN
                            prod_d  = {{XLEN{1'b0}}, a_abs};
                            opb_d   = b_abs;
                            sign1_d = a_neg;
                            sign2_d = b_neg;
                            opsel_d = op_in[1:0];
                            cnt_d   = '0;
                            if (op_in[2] && div_zero) begin
                                result_d = op_in[1] ? op_a : '1;
                                state_d  = S_HOLD;
                            end else if (op_in[2] && div_ovf) begin
                                result_d = op_in[1] ? '0 : op_a;
                                state_d  = S_HOLD;
                            end else begin
                                state_d = op_in[2] ? S_DIV : S_MUL;
                            end
`else
                            result_d = '0;
                            state_d  = S_HOLD;
`endif
                        end
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                S_MUL, S_DIV: begin
                    prod_d = step_prod;
                    cnt_d  = cnt_q + SHW'(1);
                    if (cnt_q == SHW'(XLEN-1)) begin
                        result_d = iter_res;
                        state_d  = S_HOLD;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        non_zero_d = |result_d;
    end

    // state and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            non_zero_q <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            prod_q  <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            opsel_q <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            non_zero_q <= non_zero_d;
`ifdef ALU_SEQ_MULDIV_EN
            prod_q  <= prod_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            opsel_q <= opsel_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
`endif
        end
    end

    assign ready_out    = (state_q == S_IDLE) || ((state_q == S_HOLD) && ready_in);
    assign valid_out    = (state_q == S_HOLD);
    assign result_out   = result_q;
    assign non_zero_out = non_zero_q;
`ifdef ALU_SEQ_MULDIV_EN
    assign busy_out = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign busy_out = 1'b0;
`endif

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the integer execute-stage ALU. Adds a valid/ready handshake, an output register, and an iterative RV M-extension multiplier/divider behind a small FSM, so the execute stage can stall on long operations. Sits between decode/operand-read and writeback. Single-cycle ALU ops keep their existing encodings and source muxing.

## Interface
Parameters:
- XLEN, 64, datapath width; 32 or 64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk_in, input, 1, clock; all state updates on the rising edge.
- rst_n_in, input, 1, reset; asynchronous assert, active-low.
- flush_in, input, 1, synchronous abort of the in-flight or held operation.
- valid_in, input, 1, request valid.
- ready_out, output, 1, request accepted when valid_in && ready_out.
- op_in, input, 4, 0 ADD/SUB, 1 XOR, 2 OR, 3 AND, 4 SLL, 5 SRL/SRA, 6 SLT, 7 SLTU, 8 MUL, 9 MULH, 10 MULHSU, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
- sub_sra_in, input, 1, selects SUB for op 0 and SRA for op 5.
- src1_in, input, 2, 0 rs1, 1 pc, 2 zero; 3 is illegal and yields X.
- src2_in, input, 2, 0 rs2, 1 imm, 2 constant 4; 3 is illegal and yields X.
- pc_in, rs1_value_in, rs2_value_in, imm_value_in, input, XLEN, operands.
- valid_out, output, 1, result valid.
- ready_in, input, 1, consumer ready; result retires when valid_out && ready_in.
- result_out, output, XLEN, registered result.
- non_zero_out, output, 1, |result_out, registered alongside result_out.
- busy_out, output, 1, high in MUL or DIV state.

## Operation
- FSM states: IDLE, MUL, DIV, HOLD.
- IDLE, ops 0–7 accepted: result is computed combinationally and registered. Go to HOLD with valid_out=1.
- IDLE, ops 8–11 accepted: latch the operands. MULHSU treats src1 as signed and src2 as unsigned. MULH and MULHSU take absolute values and record the result sign. Go to MUL.
- MUL: shift-add one bit per cycle for XLEN cycles. On completion, negate if needed, select the low half for op 8 or the high half otherwise, then go to HOLD.
- IDLE, ops 12–15 with divisor 0: go straight to HOLD. Quotient is all-ones; remainder is src1.
- IDLE, signed ops 12/14 with src1=−2^(XLEN−1) and src2=−1: go straight to HOLD. Quotient is src1; remainder is 0.
- IDLE, other ops 12–15: go to DIV. Restoring division, one bit per cycle for XLEN cycles, then sign fix-up. Quotient sign is sign1^sign2; remainder sign is sign1. Go to HOLD.
- HOLD: result_out and valid_out stay stable until ready_in. On retire, if valid_in is also high, the new op is accepted in the same cycle (back-to-back). Otherwise go to IDLE.
- ready_out = (state==IDLE) || (state==HOLD && ready_in).
- SLT/SLTU result is {XLEN−1 zeros, bit}.
- Shift amount is src2[SHW−1:0].
- flush_in has priority over everything. Next state is IDLE with valid_out=0, and the request presented in the flush cycle is not accepted.
- Reset: state IDLE; valid_out 0, result_out 0, non_zero_out 0, busy_out 0. Iteration counter and operand registers are cleared to 0.

## Timing
- Ops 0–7: valid_out rises the cycle after acceptance (latency 1). Throughput is 1 per cycle when ready_in is held high.
- Ops 8–11: latency XLEN+1; ready_out is low during MUL.
- Ops 12–15: latency XLEN+1. Divide-by-zero and signed overflow take latency 1.
- Backpressure: while valid_out && !ready_in, no output changes and ready_out=0.
- Reset asserted mid-iteration: all outputs return to reset values immediately (asynchronous). The first acceptance is possible on the first edge after deassertion.

## Configuration
- ALU_SEQ_MULDIV_EN defined: ops 8–15 behave as above.
- ALU_SEQ_MULDIV_EN undefined: the MUL/DIV states and datapath are absent. Ops 8–15 are accepted with latency 1 and return result_out=0. busy_out is tied to 0.

## Test plan
- XLEN=64, ADD rs1=5, rs2=7, ready_in=1 → valid_out next cycle, result 12, non_zero_out 1. SUB with the same operands → 0xFFFF_FFFF_FFFF_FFFE.
- SRA rs1=0x8000_0000_0000_0000, imm=63 → all-ones. SLTU rs1=1, rs2=−1 → 1. SLT with the same operands → 0.
- MULH rs1=−1, rs2=−1 → result 0 after 65 cycles. MUL with the same operands → 1. ready_out low throughout, busy_out high.
- DIV −7/2 → −3; REM → −1. DIVU x/0 → all-ones at latency 1. DIV 0x8000…0/−1 → 0x8000…0, REM → 0.
- ready_in held low for 5 cycles after ADD completes → result stable and ready_out 0. Raising ready_in with valid_in high and a new XOR → back-to-back acceptance, next result 1 cycle later.
- flush_in pulsed mid-DIV → valid_out never asserts, state IDLE next cycle. rst_n_in dropped mid-MUL → outputs reset asynchronously.
